// File: rtl/top_led_master.sv
// LED bar-graph pattern generator: mode-selected prescaler ticks a 4-bit counter decoded onto 16 LEDs.
// Define LED_PINGPONG_EN to make the counter bounce 0..15..0 instead of wrapping.
module top_led_master #(
   parameter int          DIV_MODE0    = 4,
   parameter int          DIV_LOW      = 256,
   parameter int          DIV_NORMAL   = 128,
   parameter int          DIV_HIGH     = 64,
   parameter logic [15:0] IDLE_PATTERN = 16'h0007
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        mini_rst,
   input  logic        start,
   input  logic        idle,
   input  logic [1:0]  mode,
   output logic [15:0] LED
);

   // divisors below 1 degrade to a tick every cycle
   localparam int D0   = (DIV_MODE0  < 1) ? 1 : DIV_MODE0;
   localparam int D1   = (DIV_LOW    < 1) ? 1 : DIV_LOW;
   localparam int D2   = (DIV_NORMAL < 1) ? 1 : DIV_NORMAL;
   localparam int D3   = (DIV_HIGH   < 1) ? 1 : DIV_HIGH;
   localparam int DA   = (D0 > D1) ? D0 : D1;
   localparam int DB   = (D2 > D3) ? D2 : D3;
   localparam int DMAX = (DA > DB) ? DA : DB;
   localparam int PW   = (DMAX > 1) ? $clog2(DMAX) : 1;

   logic [PW-1:0] presc_q, presc_d, div_m1;
   logic [3:0]    count_q, count_d;
   logic [1:0]    mode_q;
   logic [15:0]   led_d;
   logic          tick;
`ifdef LED_PINGPONG_EN
   logic          dir_q, dir_d;
`endif

   always_comb begin
      div_m1 = PW'(D0 - 1);
      case (mode)
         2'b00:   div_m1 = PW'(D0 - 1);
         2'b01:   div_m1 = PW'(D1 - 1);
         2'b10:   div_m1 = PW'(D2 - 1);
         default: div_m1 = PW'(D3 - 1);
      endcase
   end

   always_comb begin
      tick    = 1'b0;
      presc_d = presc_q;
      count_d = count_q;
`ifdef LED_PINGPONG_EN
      dir_d   = dir_q;
`endif
      if (!start) begin
         presc_d = '0;
         count_d = '0;
`ifdef LED_PINGPONG_EN
         dir_d   = 1'b0;
`endif
      end else if (mode != mode_q) begin
         presc_d = '0;
      end else if (presc_q == div_m1) begin
         presc_d = '0;
         tick    = 1'b1;
      end else begin
         presc_d = presc_q + 1'b1;
      end

      if (start && !idle && tick) begin
`ifdef LED_PINGPONG_EN
         if (dir_q) begin
            if (count_q == 4'd0) begin
               count_d = 4'd1;
               dir_d   = 1'b0;
            end else begin
               count_d = count_q - 4'd1;
            end
         end else begin
            if (count_q == 4'hF) begin
               count_d = 4'hE;
               dir_d   = 1'b1;
            end else begin
               count_d = count_q + 4'd1;
            end
         end
`else
         count_d = count_q + 4'd1;
`endif
      end

      // bar-graph of the post-update count: n lit LEDs from bit 0
      if (idle)
         led_d = IDLE_PATTERN;
      else if (start)
         led_d = (16'd1 << count_d) - 16'd1;
      else
         led_d = 16'h0000;
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         presc_q <= '0;
         count_q <= '0;
         mode_q  <= '0;
         LED     <= '0;
`ifdef LED_PINGPONG_EN
         dir_q   <= 1'b0;
`endif
      end else begin
         mode_q <= mode;
         if (mini_rst) begin
            presc_q <= '0;
            count_q <= '0;
            LED     <= '0;
`ifdef LED_PINGPONG_EN
            dir_q   <= 1'b0;
`endif
         end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            LED     <= led_d;
`ifdef LED_PINGPONG_EN
            dir_q   <= dir_d;
`endif
         end
      end
   end

endmodule

// File: tb/tb_top_led_master.sv
// Bench for top_led_master: directed plan steps then randomized run against a behavioural model.
module tb_top_led_master;

   logic        sys_clk = 1'b0;
   logic        sys_rst = 1'b0;
   logic        mini_rst = 1'b0;
   logic        start = 1'b0;
   logic        idle = 1'b0;
   logic [1:0]  mode = 2'b00;
   logic [15:0] LED;

   int total = 0;
   int bad   = 0;

   // model: prescaler phase, position along the count sequence, last seen mode, LED
   int          m_ph = 0;
   int          m_pos = 0;
   int          m_prev = 0;
   logic [15:0] m_led = '0;

   top_led_master dut (
      .sys_clk (sys_clk),
      .sys_rst (sys_rst),
      .mini_rst(mini_rst),
      .start   (start),
      .idle    (idle),
      .mode    (mode),
      .LED     (LED)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic int div_of(input int m);
      case (m)
         0:       return 4;
         1:       return 256;
         2:       return 128;
         default: return 64;
      endcase
   endfunction

   function automatic int count_of(input int pos);
`ifdef LED_PINGPONG_EN
      return (pos <= 15) ? pos : 30 - pos;
`else
      return pos;
`endif
   endfunction

   function automatic int period();
`ifdef LED_PINGPONG_EN
      return 30;
`else
      return 16;
`endif
   endfunction

   task automatic model_reset();
      m_ph = 0; m_pos = 0; m_prev = 0; m_led = '0;
   endtask

   task automatic model_edge();
      bit t;
      if (!sys_rst) begin
         model_reset();
         return;
      end
      if (mini_rst) begin
         m_ph = 0; m_pos = 0; m_led = '0;
      end else begin
         t = 0;
         if (!start) begin
            m_ph = 0; m_pos = 0;
         end else if (int'(mode) != m_prev) begin
            m_ph = 0;
         end else if (m_ph == div_of(int'(mode)) - 1) begin
            m_ph = 0; t = 1;
         end else begin
            m_ph++;
         end
         if (t && start && !idle) m_pos = (m_pos + 1) % period();
         if (idle)       m_led = 16'h0007;
         else if (start) m_led = 16'((32'd1 << count_of(m_pos)) - 32'd1);
         else            m_led = 16'h0000;
      end
      m_prev = int'(mode);
   endtask

   task automatic check(input string tag, input logic [15:0] exp);
      total++;
      assert (LED === exp) else begin
         bad++;
         $error("FAIL %s: LED=%h expected=%h", tag, LED, exp);
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge sys_clk);
      model_edge();
      #1;
      check(tag, m_led);
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) cyc(tag);
   endtask

   initial begin
      // reset held with start active
      start = 1; mode = 2'b01;
      #1 check("reset_async", 16'h0000);
      run(2, "in_reset");
      sys_rst = 1;
      run(5, "post_release");
      check("post_release_const", 16'h0000);

      run(5, "mode01");
      mode = 2'b10; run(5, "mode10");
      mode = 2'b11; run(5, "mode11");
      check("mode_chg_const", 16'h0000);

      start = 0; idle = 1;
      cyc("idle_on");
      check("idle_pattern", 16'h0007);
      start = 1;
      run(3, "idle_start");
      check("idle_over_start", 16'h0007);

      // mode0 stepping from a clean start
      idle = 0; start = 0; mode = 2'b00;
      cyc("clear");
      start = 1;
      run(4, "mode0_first");
      check("first_step", 16'h0001);
      run(44, "mode0_run");
      check("step12", 16'h0FFF);
      run(12, "mode0_run");
      check("step15", 16'h7FFF);
      run(4, "mode0_run");
`ifdef LED_PINGPONG_EN
      check("bounce", 16'h3FFF);
`else
      check("wrap", 16'h0000);
`endif

      run(10, "pre_mini");
      mini_rst = 1;
      cyc("mini_rst");
      check("mini_rst_const", 16'h0000);
      mini_rst = 0;
      run(4, "after_mini");
      check("restart_step", 16'h0001);

      // asynchronous reset between edges
      run(9, "pre_async");
      #2 sys_rst = 0;
      model_reset();
      #1 check("async_rst", 16'h0000);
      cyc("async_hold");
      sys_rst = 1;
      run(3, "async_release");

      for (int i = 0; i < 2000; i++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 3)       mode = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'($urandom_range(0, 3));
         else if (r < 5)  start = ~start;
         else if (r < 8)  idle = ~idle;
         mini_rst = (r == 99);
         if (r < 12 && !start) start = 1;
         if (r >= 20 && r < 40 && idle) idle = 0;
         cyc("random");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
